// File: rtl/tiger_exec_monitor.sv
// Execution monitor for the Tiger pipeline: run-window cycle/instruction counters and per-channel stall watchdogs.
// Optional PC history ring buffer enabled by defining TIGER_MON_PCHIST_EN.
module tiger_exec_monitor #(
  parameter int          NUM_CH     = 2,
  parameter int          WDOG_W     = 10,
  parameter int          WDOG_LIMIT = 1000,
  parameter int          CNT_W      = 64,
  parameter logic [31:0] START_PC   = 32'h0080_0000,
  parameter logic [31:0] END_PC     = 32'h0000_0010
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [31:0]       pc,
  input  logic              ins_valid,
  input  logic [NUM_CH-1:0] stall,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instr_count,
  output logic              running,
  output logic              done,
  output logic              hang,
  output logic [NUM_CH-1:0] stuck_mask,
  output logic [WDOG_W-1:0] max_stall
`ifdef TIGER_MON_PCHIST_EN
  ,
  input  logic [3:0]        hist_idx,
  output logic [31:0]       hist_pc,
  output logic [4:0]        hist_fill
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, HANG} state_t;

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(WDOG_LIMIT);

  state_t            state, state_nxt;
  logic [WDOG_W-1:0] wd [NUM_CH];
  logic [NUM_CH-1:0] wd_hit;
  logic [WDOG_W-1:0] wd_max;
  logic              retire;

  // Consecutive-stall count that holds at the limit instead of wrapping.
  function automatic logic [WDOG_W-1:0] wd_step(input logic [WDOG_W-1:0] cur, input logic stall_i);
    if (!stall_i)
      return '0;
    else if (cur >= LIMIT)
      return LIMIT;
    else
      return cur + WDOG_W'(1);
  endfunction

  assign retire = ins_valid & ~(|stall);

  always_comb begin
    wd_hit = '0;
    wd_max = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wd[i] == LIMIT) wd_hit[i] = 1'b1;
      if (wd[i] > wd_max) wd_max = wd[i];
    end
  end

  // A stuck channel outranks both window start and window end in the same cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (|wd_hit)             state_nxt = HANG;
        else if (pc == START_PC) state_nxt = RUN;
      end
      RUN: begin
        if (|wd_hit)             state_nxt = HANG;
        else if (pc == END_PC)   state_nxt = DONE;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cycle_count <= '0;
      instr_count <= '0;
      running     <= 1'b0;
      done        <= 1'b0;
      hang        <= 1'b0;
      stuck_mask  <= '0;
      max_stall   <= '0;
      for (int i = 0; i < NUM_CH; i++) wd[i] <= '0;
    end else if (clear) begin
      state       <= IDLE;
      cycle_count <= '0;
      instr_count <= '0;
      running     <= 1'b0;
      done        <= 1'b0;
      hang        <= 1'b0;
      stuck_mask  <= '0;
      max_stall   <= '0;
      for (int i = 0; i < NUM_CH; i++) wd[i] <= '0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == RUN);
      done    <= (state_nxt == DONE);
      if (state == RUN) begin
        cycle_count <= cycle_count + CNT_W'(1);
        if (retire) instr_count <= instr_count + CNT_W'(1);
        if (wd_max > max_stall) max_stall <= wd_max;
      end
      // Watchdogs freeze once hung so the stuck evidence is preserved.
      if (state != HANG) begin
        for (int i = 0; i < NUM_CH; i++) wd[i] <= wd_step(wd[i], stall[i]);
        stuck_mask <= stuck_mask | wd_hit;
        if (|wd_hit) hang <= 1'b1;
      end
    end
  end

`ifdef TIGER_MON_PCHIST_EN
  logic [31:0] hist_mem [16];
  logic [3:0]  wr_ptr;
  logic        hist_wr;

  assign hist_wr = (state == RUN) && retire && !clear;

  // Storage carries no reset so it can map onto a plain register file.
  always_ff @(posedge clk) begin
    if (hist_wr) hist_mem[wr_ptr] <= pc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      hist_fill <= '0;
      hist_pc   <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      hist_fill <= '0;
      hist_pc   <= '0;
    end else begin
      if (hist_wr) begin
        wr_ptr <= wr_ptr + 4'd1;
        if (hist_fill != 5'd16) hist_fill <= hist_fill + 5'd1;
      end
      hist_pc <= hist_mem[wr_ptr - 4'd1 - hist_idx];
    end
  end
`endif

endmodule
